reset_sequencer: RTL and testbench

Downstream consumer of the master reset output (Reset_L_Out, active-low). Turns one master reset into an ordered, handshaked release of per-stage resets: PC/fetch first, then register file, memory, control. Each stage's reset is released only after the previous stage reports ready. Reports sequence completion and a timeout error.

---
 rtl/reset_sequencer_if.sv | 37 +++
 rtl/reset_sequencer.sv | 137 +++++++++++++
 tb/tb_reset_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer_if
// Brief    : Master-reset request, stage handshakes and sequencer status.
// Revision : 1.0 - initial release
// ============================================================================
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int IDX_W      = 2
);
  logic                  Master_Reset_L;
  logic [NUM_STAGES-1:0] Stage_Ready;
  logic [NUM_STAGES-1:0] Stage_Reset_L;
  logic [IDX_W-1:0]      Cur_Stage;
  logic                  Seq_Done;
  logic                  Seq_Error;

  // master: the sequencer itself; slave: the stages and status consumers
  modport master (
    input  Master_Reset_L,
    input  Stage_Ready,
    output Stage_Reset_L,
    output Cur_Stage,
    output Seq_Done,
    output Seq_Error
  );

  modport slave (
    output Master_Reset_L,
    output Stage_Ready,
    input  Stage_Reset_L,
    input  Cur_Stage,
    input  Seq_Done,
    input  Seq_Error
  );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Brief    : Ordered, handshaked release of per-stage resets after the master
//            reset. Macro RSTSEQ_TIMEOUT_EN enables the ready timeout/ERROR.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int IDX_W          = 2,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                     CLK,
  input  logic                     Reset,
  reset_sequencer_if.master        seq_if
);

`ifdef RSTSEQ_TIMEOUT_EN
  localparam bit C_TIMEOUT_EN = 1'b1;
`else
  localparam bit C_TIMEOUT_EN = 1'b0;
`endif

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  localparam logic [CNT_W-1:0] C_HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX     = IDX_W'(NUM_STAGES - 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [IDX_W-1:0]      cur_q,   cur_d;
  logic [NUM_STAGES-1:0] srl_q,   srl_d;
  logic                  done_q,  done_d;
  logic                  err_q,   err_d;

  // Stages 0..idx out of reset, everything above still held
  function automatic logic [NUM_STAGES-1:0] stage_mask(input logic [IDX_W-1:0] idx);
    logic [NUM_STAGES-1:0] m;
    for (int i = 0; i < NUM_STAGES; i++) begin
      m[i] = (i <= int'(idx));
    end
    return m;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    srl_d   = srl_q;
    done_d  = done_q;
    err_d   = err_q;
    if (!seq_if.Master_Reset_L) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      cur_d   = '0;
      srl_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_q == C_HOLD_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            cur_d   = '0;
            srl_d   = stage_mask('0);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          // Ready is checked before timeout so a last-cycle ack still wins
          if (seq_if.Stage_Ready[cur_q]) begin
            if (cur_q == C_LAST_IDX) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              srl_d   = '1;
            end else begin
              cur_d = cur_q + IDX_W'(1);
              cnt_d = '0;
              srl_d = stage_mask(cur_q + IDX_W'(1));
            end
          end else if (C_TIMEOUT_EN && (cnt_q == C_TIMEOUT_LAST)) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            done_d  = 1'b0;
            srl_d   = '0;
          end else if (C_TIMEOUT_EN) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE, ST_ERROR: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          cur_d   = '0;
          srl_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      cur_q   <= '0;
      srl_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      srl_q   <= srl_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign seq_if.Stage_Reset_L = srl_q;
  assign seq_if.Cur_Stage     = cur_q;
  assign seq_if.Seq_Done      = done_q;
  assign seq_if.Seq_Error     = err_q & C_TIMEOUT_EN;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Directed and randomized stimulus against a stage-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;
  localparam int NUM_STAGES     = 4;
  localparam int IDX_W          = 2;
  localparam int HOLD_CYCLES    = 8;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int CNT_W          = 8;
`ifdef RSTSEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_STAGES(NUM_STAGES), .IDX_W(IDX_W)) bus ();

  reset_sequencer #(
    .NUM_STAGES(NUM_STAGES), .IDX_W(IDX_W), .HOLD_CYCLES(HOLD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .CLK(clk),
    .Reset(rst),
    .seq_if(bus.master)
  );

  // Model: how many stages are out of reset, how long we have held/waited
  int m_rel, m_held, m_wait;
  bit m_done, m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge(input bit r, input bit mrl, input logic [NUM_STAGES-1:0] rdy);
    if (r || !mrl) begin
      m_rel = 0; m_held = 0; m_wait = 0; m_done = 0; m_err = 0;
    end else if (m_done || m_err) begin
      m_wait = m_wait;
    end else if (m_rel == 0) begin
      m_held++;
      if (m_held == HOLD_CYCLES) begin
        m_rel  = 1;
        m_wait = 0;
      end
    end else if (rdy[m_rel-1]) begin
      if (m_rel == NUM_STAGES) m_done = 1;
      else begin
        m_rel++;
        m_wait = 0;
      end
    end else if (TO_EN && m_wait == TIMEOUT_CYCLES - 1) begin
      m_err = 1;
    end else begin
      m_wait++;
    end
  endfunction

  function automatic logic [31:0] exp_srl();
    if (m_err) return 32'd0;
    return (32'd1 << m_rel) - 32'd1;
  endfunction

  function automatic logic [31:0] exp_cur();
    return (m_rel == 0) ? 32'd0 : 32'(m_rel - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(rst, bus.Master_Reset_L, bus.Stage_Ready);
    #1;
    check_eq("stage_reset_l", 32'(bus.Stage_Reset_L), exp_srl());
    check_eq("cur_stage",     32'(bus.Cur_Stage),     exp_cur());
    check_eq("seq_done",      32'(bus.Seq_Done),      32'(m_done));
    check_eq("seq_error",     32'(bus.Seq_Error),     32'(m_err));
  endtask

  // 0: ack follows own reset, 1: all ready, 2: random, 3: follow but one stage stuck
  task automatic set_ready(input int mode, input int stuck);
    logic [NUM_STAGES-1:0] one;
    one = 1;
    case (mode)
      0:       bus.Stage_Ready = bus.Stage_Reset_L;
      1:       bus.Stage_Ready = '1;
      2:       bus.Stage_Ready = NUM_STAGES'($urandom);
      default: bus.Stage_Ready = bus.Stage_Reset_L & ~(one << stuck);
    endcase
  endtask

  task automatic restart(input int mode, input int stuck);
    rst = 1'b1;
    bus.Master_Reset_L = 1'b1;
    set_ready(mode, stuck);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int first;
    bus.Master_Reset_L = 1'b1;
    bus.Stage_Ready    = '0;

    // Nominal sequence, two reset edges
    repeat (2) begin
      set_ready(0, 0);
      tick();
    end
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      set_ready(0, 0);
      tick();
      if (e >= 8 && e <= 11) check_eq("nominal_release", 32'(bus.Stage_Reset_L), (32'd1 << (e - 7)) - 1);
      if (e == 12) begin
        check_eq("nominal_done", 32'(bus.Seq_Done), 32'd1);
        check_eq("nominal_cur", 32'(bus.Cur_Stage), 32'd3);
      end
    end

    // Master reset pulse mid-sequence
    restart(0, 0);
    for (int e = 1; e <= 9; e++) begin
      set_ready(0, 0);
      tick();
    end
    bus.Master_Reset_L = 1'b0;
    set_ready(0, 0);
    tick();
    check_eq("pulse_srl", 32'(bus.Stage_Reset_L), 32'd0);
    check_eq("pulse_cur", 32'(bus.Cur_Stage), 32'd0);
    bus.Master_Reset_L = 1'b1;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      set_ready(0, 0);
      tick();
      if (first == 0 && bus.Stage_Reset_L == 4'b0001) first = k;
    end
    check_eq("restart_latency", 32'(first), 32'd8);

    // Stage 2 never acks
    restart(3, 2);
    for (int e = 1; e <= 74; e++) begin
      set_ready(3, 2);
      tick();
      if (e == 10) check_eq("stuck_release2", 32'(bus.Stage_Reset_L), 32'h7);
      if (e == 74) begin
        check_eq("stuck_err", 32'(bus.Seq_Error), TO_EN ? 32'd1 : 32'd0);
        check_eq("stuck_srl", 32'(bus.Stage_Reset_L), TO_EN ? 32'd0 : 32'h7);
        check_eq("stuck_cur", 32'(bus.Cur_Stage), 32'd2);
        check_eq("stuck_done", 32'(bus.Seq_Done), 32'd0);
      end
    end

    // Stage 1 acks exactly on the last timeout cycle
    restart(3, 1);
    for (int e = 1; e <= 73; e++) begin
      set_ready((e == 73) ? 0 : 3, 1);
      tick();
      if (e == 73) begin
        check_eq("late_ack_srl", 32'(bus.Stage_Reset_L), 32'h7);
        check_eq("late_ack_err", 32'(bus.Seq_Error), 32'd0);
      end
    end

    // Ready high from the start: still one stage per edge, then reset in DONE
    restart(1, 0);
    for (int e = 1; e <= 12; e++) begin
      set_ready(1, 0);
      tick();
      if (e >= 8 && e <= 11) check_eq("early_ready_release", 32'(bus.Stage_Reset_L), (32'd1 << (e - 7)) - 1);
    end
    check_eq("early_ready_done", 32'(bus.Seq_Done), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("done_reset_srl", 32'(bus.Stage_Reset_L), 32'd0);
    check_eq("done_reset_flag", 32'(bus.Seq_Done), 32'd0);
    rst = 1'b0;

    // Long wait on stage 0
    restart(3, 0);
    for (int e = 1; e <= 209; e++) begin
      set_ready((e == 209) ? 0 : 3, 0);
      tick();
      if (e == 209) begin
        check_eq("long_wait_srl", 32'(bus.Stage_Reset_L), TO_EN ? 32'd0 : 32'h3);
        check_eq("long_wait_err", 32'(bus.Seq_Error), TO_EN ? 32'd1 : 32'd0);
      end
    end

    // Randomized scenarios
    for (int s = 0; s < 16; s++) begin
      int mode, stuck;
      mode  = int'($urandom_range(0, 3));
      stuck = int'($urandom_range(0, NUM_STAGES - 1));
      restart(mode, stuck);
      for (int c = 0; c < 150; c++) begin
        bus.Master_Reset_L = ($urandom_range(0, 63) != 0);
        set_ready(mode, stuck);
        tick();
      end
      bus.Master_Reset_L = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
